// File: rtl/sy_pkg.sv
// rtl/sy_pkg.sv - shared pipeline types and constants
// Purpose: fetch request/response types, exception record, i-cache defaults
// and the i-cache state encoding. No ports.
package sy_pkg;

  localparam int AWTH              = 32;
  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_BYTES = 16;

  localparam int                 CAUSE_W            = 4;
  localparam logic [CAUSE_W-1:0] INSTR_ACCESS_FAULT = 4'd1;

  typedef struct packed {
    logic               valid;
    logic [CAUSE_W-1:0] cause;
    logic [AWTH-1:0]    tval;
  } excp_t;

  typedef struct packed {
    logic            req;
    logic [AWTH-1:0] vaddr;
    logic            kill;
  } fetch_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [31:0] data;
    excp_t       ex;
  } fetch_rsp_t;

  typedef enum logic [2:0] {
    IC_IDLE,
    IC_LOOKUP,
    IC_REFILL_REQ,
    IC_REFILL_DATA,
    IC_RESPOND,
    IC_FLUSH
  } icache_state_e;

endpackage

// File: rtl/sy_ppl_icache_refill.sv
// rtl/sy_ppl_icache_refill.sv - line refill engine for the instruction cache
// Purpose: issues one line read, collects BEATS words into a line buffer and
// tracks a sticky bus-error flag.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   start_i, line_addr_i load the line address and clear the error flag
//   req_phase_i          parent is waiting for the grant
//   data_phase_i         parent is collecting beats
//   mem_*                beat-based memory read port
//   done_o               last beat is being accepted this cycle
//   line_o, err_o        finished line and sticky error
module sy_ppl_icache_refill #(
  parameter int AWTH  = 32,
  parameter int BEATS = 4,
  parameter int OFF_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [AWTH-OFF_W-1:0]  line_addr_i,
  input  logic                   req_phase_i,
  input  logic                   data_phase_i,
  output logic                   mem_req_o,
  output logic [AWTH-1:0]        mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   done_o,
  output logic [BEATS-1:0][31:0] line_o,
  output logic                   err_o
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [AWTH-1:0]        addr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BEATS-1:0][31:0] line_q;
  logic                   err_q;
  logic                   last_beat;

  assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
  assign mem_req_o  = req_phase_i;
  assign mem_addr_o = addr_q;
  assign done_o     = data_phase_i && mem_rvalid_i && last_beat;
  assign line_o     = line_q;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_i) begin
        addr_q <= {line_addr_i, {OFF_W{1'b0}}};
        err_q  <= 1'b0;
      end
      if (req_phase_i && mem_gnt_i) begin
        cnt_q <= '0;
      end else if (data_phase_i && mem_rvalid_i) begin
        line_q[cnt_q] <= mem_rdata_i;
        cnt_q         <= cnt_q + 1'b1;
        // Any faulty beat poisons the whole line.
        if (mem_err_i) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sy_ppl_icache.sv
// rtl/sy_ppl_icache.sv - direct-mapped read-only instruction cache
// Purpose: responder for fetch requests; hits answer one cycle after accept,
// misses refill a full line from memory before answering.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   fet_icache__dreq_i     fetch request (req, vaddr, kill)
//   icache_fet__drsp_o     fetch response (ready, valid, data, ex)
//   fence_i_i              invalidate all lines
//   mem_req_o, mem_addr_o  refill request and line-aligned address
//   mem_gnt_i              refill request accepted
//   mem_rvalid_i, mem_rdata_i, mem_err_i  refill beats
module sy_ppl_icache
  import sy_pkg::*;
#(
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_BYTES = ICACHE_LINE_BYTES,
  parameter int AWTH       = sy_pkg::AWTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  fetch_req_t      fet_icache__dreq_i,
  output fetch_rsp_t      icache_fet__drsp_o,
  input  logic            fence_i_i,
  output logic            mem_req_o,
  output logic [AWTH-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i,
  input  logic            mem_err_i
);

  localparam int BEATS  = LINE_BYTES / 4;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = AWTH - OFF_W - IDX_W;
  localparam int WSEL_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  icache_state_e state_q, state_d;

  logic [AWTH-1:0]        cap_vaddr_q;
  logic                   fence_pend_q;
  logic                   kill_pend_q;
  logic [SETS-1:0]        valid_q;

  logic [TAG_W-1:0]       tag_mem  [SETS];
  logic [BEATS-1:0][31:0] data_mem [SETS];
  logic [TAG_W-1:0]       rd_tag_q;
  logic [BEATS-1:0][31:0] rd_line_q;

  logic [IDX_W-1:0]       req_idx;
  logic [IDX_W-1:0]       cap_idx;
  logic [TAG_W-1:0]       cap_tag;
  logic [WSEL_W-1:0]      word_sel;

  logic                   fence_any;
  logic                   hit;
  logic                   ready;
  logic                   accept;
  logic                   rsp_valid;
  logic                   rsp_err;
  logic [31:0]            rsp_data;
  logic                   refill_start;
  logic                   install;
  logic                   flush;

  logic                   refill_done;
  logic [BEATS-1:0][31:0] refill_line;
  logic                   refill_err;

  assign req_idx   = fet_icache__dreq_i.vaddr[OFF_W +: IDX_W];
  assign cap_idx   = cap_vaddr_q[OFF_W +: IDX_W];
  assign cap_tag   = cap_vaddr_q[AWTH-1 -: TAG_W];
  assign fence_any = fence_i_i || fence_pend_q;
  assign hit       = valid_q[cap_idx] && (rd_tag_q == cap_tag);

  if (BEATS > 1) begin : g_wsel
    assign word_sel = cap_vaddr_q[2 +: WSEL_W];
  end else begin : g_wsel_one
    assign word_sel = '0;
  end

  // A pending fence must be serviced before anything new is accepted, so it
  // closes the hit pipeline as well as the idle accept.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IC_IDLE:   ready = !fence_any;
      IC_LOOKUP: ready = hit && !fence_any && !fet_icache__dreq_i.kill;
      default:   ready = 1'b0;
    endcase
    if (!rst_ni) ready = 1'b0;
  end

  assign accept = fet_icache__dreq_i.req && ready && !fet_icache__dreq_i.kill;

  always_comb begin
    state_d      = state_q;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_data     = '0;
    refill_start = 1'b0;
    install      = 1'b0;
    flush        = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (fence_any)   state_d = IC_FLUSH;
        else if (accept) state_d = IC_LOOKUP;
      end
      IC_LOOKUP: begin
        if (fet_icache__dreq_i.kill) begin
          state_d = fence_any ? IC_FLUSH : IC_IDLE;
        end else if (hit) begin
          rsp_valid = 1'b1;
          rsp_data  = rd_line_q[word_sel];
          if (fence_any)   state_d = IC_FLUSH;
          else if (accept) state_d = IC_LOOKUP;
          else             state_d = IC_IDLE;
        end else begin
          refill_start = 1'b1;
          state_d      = IC_REFILL_REQ;
        end
      end
      IC_REFILL_REQ: begin
        if (mem_gnt_i) state_d = IC_REFILL_DATA;
      end
      IC_REFILL_DATA: begin
        if (refill_done) state_d = IC_RESPOND;
      end
      IC_RESPOND: begin
        rsp_valid = !kill_pend_q && !fet_icache__dreq_i.kill;
        if (refill_err) begin
          rsp_err = rsp_valid;
        end else begin
          install  = 1'b1;
          rsp_data = refill_line[word_sel];
        end
        state_d = fence_any ? IC_FLUSH : IC_IDLE;
      end
      IC_FLUSH: begin
        flush   = 1'b1;
        state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_comb begin
    icache_fet__drsp_o          = '0;
    icache_fet__drsp_o.ready    = ready;
    icache_fet__drsp_o.valid    = rsp_valid;
    icache_fet__drsp_o.data     = rsp_err ? 32'd0 : rsp_data;
    icache_fet__drsp_o.ex.valid = rsp_err;
    icache_fet__drsp_o.ex.cause = rsp_err ? INSTR_ACCESS_FAULT : '0;
    icache_fet__drsp_o.ex.tval  = rsp_err ? cap_vaddr_q : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IC_IDLE;
      cap_vaddr_q  <= '0;
      fence_pend_q <= 1'b0;
      kill_pend_q  <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cap_vaddr_q <= fet_icache__dreq_i.vaddr;

      if (flush)                                fence_pend_q <= 1'b0;
      else if (fence_i_i && state_q != IC_IDLE) fence_pend_q <= 1'b1;

      // A kill during refill only suppresses the answer; the line still lands.
      if (state_q == IC_IDLE || state_q == IC_RESPOND)
        kill_pend_q <= 1'b0;
      else if (fet_icache__dreq_i.kill &&
               (state_q == IC_REFILL_REQ || state_q == IC_REFILL_DATA))
        kill_pend_q <= 1'b1;

      if (flush)        valid_q          <= '0;
      else if (install) valid_q[cap_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: synchronous write on install, registered read on accept.
  always_ff @(posedge clk_i) begin
    if (install) begin
      tag_mem[cap_idx]  <= cap_tag;
      data_mem[cap_idx] <= refill_line;
    end
    if (accept) begin
      rd_tag_q  <= tag_mem[req_idx];
      rd_line_q <= data_mem[req_idx];
    end
  end

  sy_ppl_icache_refill #(
    .AWTH  (AWTH),
    .BEATS (BEATS),
    .OFF_W (OFF_W)
  ) u_refill (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (refill_start),
    .line_addr_i  (cap_vaddr_q[AWTH-1:OFF_W]),
    .req_phase_i  (state_q == IC_REFILL_REQ),
    .data_phase_i (state_q == IC_REFILL_DATA),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .done_o       (refill_done),
    .line_o       (refill_line),
    .err_o        (refill_err)
  );

endmodule

// File: tb/tb_sy_ppl_icache.sv
// tb/tb_sy_ppl_icache.sv - directed self-checking bench for sy_ppl_icache
module tb_sy_ppl_icache;
  import sy_pkg::*;

  localparam int SETS       = 64;
  localparam int LINE_BYTES = 16;
  localparam int BEATS      = LINE_BYTES / 4;

  logic            clk = 1'b0;
  logic            rst_n;
  fetch_req_t      dreq;
  fetch_rsp_t      drsp;
  logic            fence;
  logic            mem_req;
  logic [AWTH-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            mem_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sy_ppl_icache #(
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES),
    .AWTH       (AWTH)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .fet_icache__dreq_i (dreq),
    .icache_fet__drsp_o (drsp),
    .fence_i_i          (fence),
    .mem_req_o          (mem_req),
    .mem_addr_o         (mem_addr),
    .mem_gnt_i          (mem_gnt),
    .mem_rvalid_i       (mem_rvalid),
    .mem_rdata_i        (mem_rdata),
    .mem_err_i          (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse one request; returns at the start of the lookup cycle.
  task automatic issue(input logic [AWTH-1:0] addr);
    dreq.req   = 1'b1;
    dreq.vaddr = addr;
    tick();
    dreq.req = 1'b0;
  endtask

  // Zero-wait memory: grant on first sight of mem_req, then BEATS beats of
  // d0, d0+1, ... Returns at the start of the respond cycle.
  task automatic serve_refill(input logic [31:0] d0, input int err_beat,
                              input int kill_beat, output logic [AWTH-1:0] addr_seen,
                              output bit ok);
    ok        = 1'b0;
    addr_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        addr_seen = mem_addr;
        ok        = 1'b1;
        mem_gnt   = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    tick();
    mem_gnt = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + 32'(b);
      mem_err    = (b == err_beat);
      dreq.kill  = (b == kill_beat);
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    dreq.kill  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    dreq       = '0;
    fence      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (drsp.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", drsp.ready); end
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", drsp.valid); end
    checks++; if (drsp.ex !== '0) begin errors++; $display("FAIL reset_ex: got %h want 0", drsp.ex); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (drsp.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", drsp.ready); end
    tick();
  endtask

  task automatic test_cold_miss();
    int t0;
    logic [AWTH-1:0] a;
    bit ok;
    t0 = cyc;
    issue(32'h1000);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL cold_lookup_valid: got %b want 0", drsp.valid); end
    serve_refill(32'hA0, -1, -1, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cold_grant_timeout: got 0 want 1"); end
    checks++; if (a !== 32'h1000) begin errors++; $display("FAIL cold_mem_addr: got %h want 00001000", a); end
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1) begin errors++; $display("FAIL cold_valid: got %b want 1", drsp.valid); end
    checks++; if (drsp.data !== 32'hA0) begin errors++; $display("FAIL cold_data: got %h want 000000a0", drsp.data); end
    checks++; if (drsp.ex.valid !== 1'b0) begin errors++; $display("FAIL cold_ex: got %b want 0", drsp.ex.valid); end
    checks++; if (cyc - t0 !== 7) begin errors++; $display("FAIL cold_latency: got %0d want 7", cyc - t0); end
    tick();
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL cold_single_pulse: got %b want 0", drsp.valid); end
    tick();
  endtask

  task automatic test_hit_stream();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hA1;
    exp_data[1] = 32'hA2;
    exp_data[2] = 32'hA3;
    dreq.req   = 1'b1;
    dreq.vaddr = 32'h1004;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) dreq.vaddr = 32'h1008 + 32'(4 * i);
      else       dreq.req = 1'b0;
      @(negedge clk);
      checks++; if (drsp.valid !== 1'b1) begin errors++; $display("FAIL hit_valid[%0d]: got %b want 1", i, drsp.valid); end
      checks++; if (drsp.data !== exp_data[i]) begin errors++; $display("FAIL hit_data[%0d]: got %h want %h", i, drsp.data, exp_data[i]); end
      checks++; if (drsp.ready !== 1'b1) begin errors++; $display("FAIL hit_ready[%0d]: got %b want 1", i, drsp.ready); end
    end
    tick();
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL hit_end_valid: got %b want 0", drsp.valid); end
    tick();
  endtask

  task automatic test_bus_error();
    logic [AWTH-1:0] a;
    bit ok;
    issue(32'h2000);
    serve_refill(32'hB0, 2, -1, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_grant_timeout: got 0 want 1"); end
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1) begin errors++; $display("FAIL err_valid: got %b want 1", drsp.valid); end
    checks++; if (drsp.ex.valid !== 1'b1) begin errors++; $display("FAIL err_ex_valid: got %b want 1", drsp.ex.valid); end
    checks++; if (drsp.ex.cause !== 4'd1) begin errors++; $display("FAIL err_cause: got %0d want 1", drsp.ex.cause); end
    checks++; if (drsp.ex.tval !== 32'h2000) begin errors++; $display("FAIL err_tval: got %h want 00002000", drsp.ex.tval); end
    checks++; if (drsp.data !== 32'h0) begin errors++; $display("FAIL err_data: got %h want 0", drsp.data); end
    tick();
    issue(32'h2000);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL err_rerequest_misses: got %b want 0", drsp.valid); end
    serve_refill(32'hB0, -1, -1, a, ok);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hB0 || drsp.ex.valid !== 1'b0) begin
      errors++; $display("FAIL err_retry_rsp: got v=%b d=%h ex=%b want v=1 d=000000b0 ex=0", drsp.valid, drsp.data, drsp.ex.valid);
    end
    tick();
  endtask

  task automatic test_kill_refill();
    logic [AWTH-1:0] a;
    bit ok;
    issue(32'h3000);
    serve_refill(32'hC0, -1, 1, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL kill_grant_timeout: got 0 want 1"); end
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL kill_suppressed: got %b want 0", drsp.valid); end
    tick();
    issue(32'h3004);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hC1) begin
      errors++; $display("FAIL kill_line_installed: got v=%b d=%h want v=1 d=000000c1", drsp.valid, drsp.data);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [AWTH-1:0] a;
    bit ok;
    issue(32'h1000);
    serve_refill(32'hA0, -1, -1, a, ok);
    @(negedge clk);
    checks++; if (drsp.data !== 32'hA0) begin errors++; $display("FAIL conf_fill_data: got %h want 000000a0", drsp.data); end
    tick();
    issue(32'h1000 + SETS * LINE_BYTES);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL conf_alias_miss: got %b want 0", drsp.valid); end
    serve_refill(32'hD0, -1, -1, a, ok);
    checks++; if (a !== 32'h1400) begin errors++; $display("FAIL conf_alias_addr: got %h want 00001400", a); end
    @(negedge clk);
    checks++; if (drsp.data !== 32'hD0) begin errors++; $display("FAIL conf_alias_data: got %h want 000000d0", drsp.data); end
    tick();
    issue(32'h1000);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL conf_evicted_miss: got %b want 0", drsp.valid); end
    serve_refill(32'hA0, -1, -1, a, ok);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hA0) begin
      errors++; $display("FAIL conf_refill_rsp: got v=%b d=%h want v=1 d=000000a0", drsp.valid, drsp.data);
    end
    tick();
  endtask

  task automatic test_fence();
    logic [AWTH-1:0] a;
    bit ok;
    dreq.req   = 1'b1;
    dreq.vaddr = 32'h1004;
    tick();
    dreq.vaddr = 32'h1008;
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hA1) begin
      errors++; $display("FAIL fence_hit0: got v=%b d=%h want v=1 d=000000a1", drsp.valid, drsp.data);
    end
    tick();
    dreq.vaddr = 32'h100C;
    fence      = 1'b1;
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hA2) begin
      errors++; $display("FAIL fence_hit1: got v=%b d=%h want v=1 d=000000a2", drsp.valid, drsp.data);
    end
    checks++; if (drsp.ready !== 1'b0) begin errors++; $display("FAIL fence_ready_closed: got %b want 0", drsp.ready); end
    tick();
    fence      = 1'b0;
    dreq.vaddr = 32'h1000;
    @(negedge clk);
    checks++; if (drsp.ready !== 1'b0 || drsp.valid !== 1'b0) begin
      errors++; $display("FAIL fence_flush_cycle: got r=%b v=%b want r=0 v=0", drsp.ready, drsp.valid);
    end
    tick();
    @(negedge clk);
    checks++; if (drsp.ready !== 1'b1) begin errors++; $display("FAIL fence_one_flush_cycle: got %b want 1", drsp.ready); end
    tick();
    dreq.req = 1'b0;
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL fence_miss_after: got %b want 0", drsp.valid); end
    serve_refill(32'hA0, -1, -1, a, ok);
    checks++; if (!ok || a !== 32'h1000) begin errors++; $display("FAIL fence_refill_addr: got %h want 00001000", a); end
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hA0) begin
      errors++; $display("FAIL fence_refill_rsp: got v=%b d=%h want v=1 d=000000a0", drsp.valid, drsp.data);
    end
    tick();
  endtask

  task automatic test_kill_lookup();
    issue(32'h1004);
    dreq.kill = 1'b1;
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0) begin errors++; $display("FAIL klook_valid: got %b want 0", drsp.valid); end
    tick();
    dreq.kill = 1'b0;
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL klook_idle: got v=%b mreq=%b want 0 0", drsp.valid, mem_req);
    end
    tick();
    dreq.req   = 1'b1;
    dreq.kill  = 1'b1;
    dreq.vaddr = 32'h1008;
    tick();
    dreq.req  = 1'b0;
    dreq.kill = 1'b0;
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b0 || drsp.ready !== 1'b1) begin
      errors++; $display("FAIL klook_req_dropped: got v=%b r=%b want v=0 r=1", drsp.valid, drsp.ready);
    end
    tick();
    issue(32'h1008);
    @(negedge clk);
    checks++; if (drsp.valid !== 1'b1 || drsp.data !== 32'hA2) begin
      errors++; $display("FAIL klook_hit_after: got v=%b d=%h want v=1 d=000000a2", drsp.valid, drsp.data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_bus_error();
    test_kill_refill();
    test_conflict();
    test_fence();
    test_kill_lookup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
